rng_burst_arbiter: RTL and testbench
====================================

# rng_burst_arbiter

- Shares one xorshift32 generator (shifts a=13, b=17, c=5) between NUM_REQ requesters.
- Each requester submits a seed and a burst length.
- The block grants requesters round-robin, then streams that requester's burst of random words on a single ready/valid output tagged with the requester id.
- It sits between the seed-producing front ends and the FIFO write side of the random-number path; the FIFO's not-full flag drives `out_ready`.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of out_id; equals clog2(NUM_REQ)
- LEN_W, 8, width of each length field; burst beat count = len+1 (1..2^LEN_W)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a pending burst request
- req_seed  in  32*NUM_REQ  seed of requester i at bits [32i+31:32i]
- req_len  in  LEN_W*NUM_REQ  length field of requester i at bits [LEN_W*i+LEN_W-1:LEN_W*i]
- req_ready  out  NUM_REQ  one-hot, one-cycle grant; request i is accepted in the cycle req_valid[i] & req_ready[i]
- out_valid  out  1  out_data / out_id / out_last valid
- out_data  out  32  random word
- out_id  out  ID_W  index of the requester owning the current burst
- out_last  out  1  marks the final beat of a burst
- out_ready  in  1  downstream accepts the beat (FIFO not full)
- busy  out  1  high while in RUN

## Operation
- Two states: IDLE and RUN.
- Internal registers:
  - rr_ptr (ID_W)
  - gnt_id (ID_W)
  - beat_cnt (LEN_W)
  - data register x (32)
- xorshift step f(v):
  - t1 = v ^ (v<<13)
  - t2 = t1 ^ (t1>>17)
  - f = t2 ^ (t2<<5)
  - All shifts are logical and 32-bit, with overflow bits discarded.
- IDLE:
  - busy=0, out_valid=0, req_ready=0 unless a grant occurs.
  - If any req_valid bit is set, g = the first index at or after rr_ptr (cyclic search) with req_valid[g]=1.
  - req_ready[g]=1 combinationally in the same cycle.
  - On that edge: x <= f(seed_g'), beat_cnt <= req_len[g], gnt_id <= g, state <= RUN.
  - seed_g' = req_seed[g], except that a seed of 0 is replaced by 32'h0000_0001 (all-zero is a fixed point of xorshift).
- RUN:
  - busy=1, out_valid=1, out_data=x, out_id=gnt_id, out_last=(beat_cnt==0).
  - req_ready=0 for all requesters.
  - On a handshake (out_valid & out_ready) with beat_cnt!=0: x <= f(x), beat_cnt <= beat_cnt-1.
  - On a handshake with beat_cnt==0: state <= IDLE, rr_ptr <= (gnt_id+1) mod NUM_REQ.
  - With out_ready=0: out_data, out_id, out_last and out_valid hold unchanged.
- req_valid falling on a non-granted requester has no effect; no request state is stored outside a grant.
- With NUM_REQ not a power of two, rr_ptr wraps from NUM_REQ-1 to 0.

## Timing
- Reset state:
  - state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0, x=0.
  - Outputs: out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, req_ready=0.
- Reset overrides all activity. Asserting rst mid-burst aborts the burst: out_valid=0 from the cycle after the reset edge, and the remaining beats are discarded.
- Grant-to-data latency:
  - Grant in cycle T; first beat valid in T+1.
  - With out_ready held high, beat k appears at T+1+k.
- Burst-to-burst gap:
  - Last handshake at cycle L; IDLE in L+1 (grant possible); next first beat at L+2.
  - This is a one-cycle bubble on out_valid.
- Throughput inside a burst is one beat per cycle while out_ready=1.
- Grant happens only in IDLE. Requests arriving during RUN wait.
- Fairness: a requester that holds req_valid high is granted within NUM_REQ bursts.

## Test plan
- Reset, then req_valid=4'b0001, seed0=1, len0=1 with out_ready=1:
  - req_ready=4'b0001 for one cycle.
  - Beats are 32'h0004_2021 then 32'h0408_0601 (out_last=1), both with out_id=0.
  - busy falls the cycle after the last beat.
- Same request with out_ready toggling 1,0,0,1:
  - out_data, out_last and out_id stay stable while out_ready=0.
  - Exactly 2 beats are delivered, with no duplicates or skips.
- All four requesters held valid with len=0 and distinct seeds:
  - Grant order is 0,1,2,3,0.
  - out_id follows that order.
  - Each grant is separated by the one-cycle bubble.
- seed2=0, len2=0, only requester 2 valid: a single beat of 32'h0004_2021 with out_id=2 (zero seed substituted).
- len0=8'hFF: exactly 256 beats. out_last is asserted only on beat 256, and beat_cnt wraps to no further beats.
- rst pulsed during beat 3 of a 6-beat burst:
  - out_valid=0 and busy=0 the next cycle.
  - rr_ptr=0 afterwards: with requesters 1 and 0 valid, the next grant goes to requester 0.

Source files
------------

// File: rtl/rng_burst_arbiter_if.sv
// Bundle of request, grant and output-stream signals for rng_burst_arbiter.
// slave: the arbiter's view. master: the requesters' and the sink's view.
interface rng_burst_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [32*NUM_REQ-1:0]    req_seed;
  logic [LEN_W*NUM_REQ-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [31:0]              out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_last;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  req_valid, req_seed, req_len, out_ready,
    output req_ready, out_valid, out_data, out_id, out_last, busy
  );

  modport master (
    output req_valid, req_seed, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/rng_burst_arbiter.sv
// Round-robin arbiter that shares one xorshift32 generator between requesters
// and streams each granted burst of random words on a ready/valid output.
module rng_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  rng_burst_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        x_q, x_d;

  logic               found_s;
  logic [ID_W-1:0]    pick_s;
  logic [ID_W-1:0]    idx_s;
  logic [31:0]        seed_s;
  logic [LEN_W-1:0]   len_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               hs_s;

  function automatic logic [31:0] xorshift32(input logic [31:0] v);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = v ^ (v << 13);
    t2 = t1 ^ (t1 >> 17);
    return t2 ^ (t2 << 5);
  endfunction

  // Cyclic search for the first valid requester at or after rr_q.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!found_s && bus.req_valid[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign seed_s = bus.req_seed[32*pick_s +: 32];
  assign len_s  = bus.req_len[LEN_W*pick_s +: LEN_W];
  assign hs_s   = (state_q == RUN) && bus.out_ready;

  // Next-state logic for the IDLE/RUN controller and its datapath registers.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    ready_s = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          ready_s = NUM_REQ'(1) << pick_s;
          // All-zero is a fixed point of xorshift, so a zero seed becomes 1.
          x_d     = xorshift32((seed_s == 32'h0000_0000) ? 32'h0000_0001 : seed_s);
          cnt_d   = len_s;
          gnt_d   = pick_s;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hs_s) begin
          if (cnt_q != '0) begin
            x_d   = xorshift32(x_q);
            cnt_d = cnt_q - LEN_W'(1);
          end else begin
            state_d = IDLE;
            rr_d    = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      x_q     <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.out_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_data  = x_q;
  assign bus.out_id    = gnt_q;
  assign bus.out_last  = (state_q == RUN) && (cnt_q == '0);

endmodule

// File: tb/tb_rng_burst_arbiter.sv
// Self-checking bench for rng_burst_arbiter: scoreboard of expected beats,
// a table of single-requester bursts, and hand-written multi-cycle sequences.
module tb_rng_burst_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 8;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   beats_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rng_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  rng_burst_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            last;
  } beat_t;

  typedef struct {
    int          id;
    logic [31:0] seed;
    logic [7:0]  len;
    logic [31:0] exp_first;
  } vec_t;

  beat_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_f(input logic [31:0] v);
    logic [31:0] a;
    a = v ^ {v[18:0], 13'h0000};
    a = a ^ {17'h00000, a[31:17]};
    a = a ^ {a[26:0], 5'h00};
    return a;
  endfunction

  task automatic push_burst(input int id, input logic [31:0] seed, input logic [7:0] len);
    logic [31:0] v;
    beat_t b;
    v = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k <= int'(len); k++) begin
      v = model_f(v);
      b.id   = ID_W'(id);
      b.data = v;
      b.last = (k == int'(len));
      sb.push_back(b);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] seed, input logic [7:0] len);
    bus.req_seed[32*id +: 32]       = seed;
    bus.req_len[LEN_W*id +: LEN_W]  = len;
  endtask

  task automatic wait_grant(input string name, output logic [NUM_REQ-1:0] g, output int t);
    g = '0;
    t = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        g = bus.req_ready;
        t = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: no grant within 50 cycles", name);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: burst not finished, %0d beats outstanding", name, sb.size());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare on each handshake plus stall stability.
  initial begin
    beat_t       e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [ID_W-1:0] prev_id = '0;
    logic        prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.req_ready != '0)
          check("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
        if (prev_stall) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_data", bus.out_data, prev_data);
          check("stall_id", 32'(bus.out_id), 32'(prev_id));
          check("stall_last", 32'(bus.out_last), 32'(prev_last));
        end
        if (bus.out_valid && bus.out_ready) begin
          beats_seen++;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: got data %0h with no beat expected", bus.out_data);
          end else begin
            e = sb.pop_front();
            check("beat_data", bus.out_data, e.data);
            check("beat_id", 32'(bus.out_id), 32'(e.id));
            check("beat_last", 32'(bus.out_last), 32'(e.last));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_id    = bus.out_id;
        prev_last  = bus.out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vecs[4];
    logic [NUM_REQ-1:0] g;
    int              t, t_prev, base;
    int              exp_order[5];

    vecs[0] = '{1, 32'h8000_0000, 8'd2, 32'h8008_4000};
    vecs[1] = '{0, 32'h0000_0002, 8'd0, 32'h0008_4042};
    vecs[2] = '{2, 32'h0000_0000, 8'd0, 32'h0004_2021};
    vecs[3] = '{3, 32'hFFFF_FFFF, 8'd3, 32'h0003_E01F};
    exp_order = '{0, 1, 2, 3, 0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_seed  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;

    // Basic two-beat burst from requester 0 with seed 1.
    set_req(0, 32'h1, 8'd1);
    push_burst(0, 32'h1, 8'd1);
    bus.req_valid = 4'b0001;
    wait_grant("t1_grant", g, t);
    check("t1_ready", 32'(g), 32'h1);
    check("t1_grant_no_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_ready_one_cycle", 32'(bus.req_ready), 32'd0);
    check("t1_beat0", bus.out_data, 32'h0004_2021);
    check("t1_beat0_last", 32'(bus.out_last), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t1_beat1", bus.out_data, 32'h0408_0601);
    check("t1_beat1_last", 32'(bus.out_last), 32'd1);
    @(negedge clk);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Same request with out_ready toggling 1,0,0,1.
    base = beats_seen;
    push_burst(0, 32'h1, 8'd1);
    step();
    bus.req_valid = 4'b0001;
    wait_grant("t2_grant", g, t);
    step();
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    bus.out_ready = 1'b0;
    step();
    bus.out_ready = 1'b1;
    wait_done("t2_done", 20);
    check("t2_beats", 32'(beats_seen - base), 32'd2);

    // Table of single-requester bursts.
    for (int i = 0; i < 4; i++) begin
      step();
      set_req(vecs[i].id, vecs[i].seed, vecs[i].len);
      push_burst(vecs[i].id, vecs[i].seed, vecs[i].len);
      bus.req_valid = NUM_REQ'(1) << vecs[i].id;
      wait_grant("tbl_grant", g, t);
      check("tbl_ready", 32'(g), 32'(NUM_REQ'(1) << vecs[i].id));
      step();
      bus.req_valid = '0;
      @(negedge clk);
      check("tbl_first", bus.out_data, vecs[i].exp_first);
      check("tbl_id", 32'(bus.out_id), 32'(vecs[i].id));
      wait_done("tbl_done", 20);
    end

    // All four held valid, len 0: order 0,1,2,3,0 with one bubble each.
    step();
    set_req(0, 32'h11, 8'd0);
    set_req(1, 32'h22, 8'd0);
    set_req(2, 32'h33, 8'd0);
    set_req(3, 32'h44, 8'd0);
    for (int k = 0; k < 5; k++) push_burst(exp_order[k], 32'((exp_order[k] + 1) * 32'h11), 8'd0);
    bus.req_valid = 4'b1111;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr_grant", g, t);
      check("rr_order", 32'(g), 32'(NUM_REQ'(1) << exp_order[k]));
      check("rr_bubble", 32'(bus.out_valid), 32'd0);
      if (k > 0) check("rr_gap", 32'(t - t_prev), 32'd2);
      t_prev = t;
    end
    step();
    bus.req_valid = '0;
    wait_done("rr_done", 20);

    // Maximum length: 256 beats, last only on the final one.
    base = beats_seen;
    step();
    set_req(0, 32'h1234_5678, 8'hFF);
    push_burst(0, 32'h1234_5678, 8'hFF);
    bus.req_valid = 4'b0001;
    wait_grant("max_grant", g, t);
    step();
    bus.req_valid = '0;
    wait_done("max_done", 400);
    check("max_beats", 32'(beats_seen - base), 32'd256);

    // Reset during beat 3 of a 6-beat burst from requester 2.
    step();
    set_req(2, 32'h0000_ABCD, 8'd5);
    push_burst(2, 32'h0000_ABCD, 8'd5);
    bus.req_valid = 4'b0100;
    wait_grant("rst_grant", g, t);
    step();
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_beats_left", 32'(sb.size()), 32'd4);
    sb.delete();
    step();
    set_req(0, 32'h5, 8'd0);
    set_req(1, 32'h6, 8'd0);
    push_burst(0, 32'h5, 8'd0);
    bus.req_valid = 4'b0011;
    wait_grant("post_rst_grant", g, t);
    check("post_rst_rr", 32'(g), 32'h1);
    step();
    bus.req_valid = '0;
    wait_done("post_rst_done", 20);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
